// File: rtl/d_mem_arbiter.sv
// d_mem_arbiter
//   Shares the single address/write port of the 64 x 64-bit data memory between
//   requester A (load/store path) and requester B (debug/loader). Accesses are
//   serialised IDLE -> ACCESS -> RESP with round-robin fairness when both ports
//   request together; load data is registered per port and a one-cycle ack is
//   returned to the owner.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata     requester A request (held until a_ack)
//   a_ack/a_rdata                 A completion pulse and registered load data
//   b_*                           same set for requester B
//   d_mem_addr/d_mem_we/
//   d_mem_data_in                 memory address, write enable, write data
//   d_mem_data_out                memory read data (combinational from address)
//   busy                          high while in ACCESS or RESP
//
// state  | meaning
// IDLE   | waiting for a request; arbitrate and latch owner
// ACCESS | memory port driven by owner; write or capture read data at edge
// RESP   | ack pulse to owner; priority passes to the other port
module d_mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] d_mem_addr,
  output logic              d_mem_we,
  output logic [DATA_W-1:0] d_mem_data_in,
  input  logic [DATA_W-1:0] d_mem_data_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  // owner / prio encoding: 0 = A, 1 = B
  logic                owner_q, owner_d;
  logic                prio_q, prio_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;

  logic                own_we;
  logic [ADDR_W-1:0]   own_addr;
  logic [DATA_W-1:0]   own_wdata;
  logic                in_access;

  assign own_we    = owner_q ? b_we    : a_we;
  assign own_addr  = owner_q ? b_addr  : a_addr;
  assign own_wdata = owner_q ? b_wdata : a_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      prio_q    <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      prio_q    <= prio_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    prio_d    = prio_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          // A lone requester wins regardless of prio; prio only breaks ties.
          owner_d = (a_req && b_req) ? prio_q : b_req;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!own_we) begin
          if (owner_q) b_rdata_d = d_mem_data_out;
          else         a_rdata_d = d_mem_data_out;
        end
        state_d = RESP;
      end
      RESP: begin
        prio_d  = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs decode straight from the state register so that an
  // asynchronous reset removes the write enable in the same cycle.
  assign in_access     = (state_q == ACCESS);
  assign d_mem_we      = in_access & own_we;
  assign d_mem_addr    = in_access ? own_addr  : '0;
  assign d_mem_data_in = in_access ? own_wdata : '0;

  assign a_ack   = (state_q == RESP) && !owner_q;
  assign b_ack   = (state_q == RESP) &&  owner_q;
  assign busy    = (state_q != IDLE);
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_d_mem_arbiter.sv
module tb_d_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [5:0]  a_addr, b_addr;
  logic [63:0] a_wdata, b_wdata;
  logic        a_ack, b_ack;
  logic [63:0] a_rdata, b_rdata;
  logic [5:0]  d_mem_addr;
  logic        d_mem_we;
  logic [63:0] d_mem_data_in, d_mem_data_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  d_mem_arbiter #(.ADDR_W(6), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .d_mem_addr(d_mem_addr), .d_mem_we(d_mem_we),
    .d_mem_data_in(d_mem_data_in), .d_mem_data_out(d_mem_data_out),
    .busy(busy)
  );

  // Memory model: writes on rising edge, combinational read; preload port
  // lets the bench seed contents without a second writer process.
  logic [63:0] mem [64];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_addr = '0;
  logic [63:0] pre_data = '0;
  always @(posedge clk) begin
    if (d_mem_we)    mem[d_mem_addr] <= d_mem_data_in;
    else if (pre_en) mem[pre_addr]   <= pre_data;
  end
  assign d_mem_data_out = mem[d_mem_addr];

  // Scoreboard: expected rdata per completed access, pushed at issue time.
  logic [63:0] ref_mem [64];
  logic [63:0] exp_a, exp_b;
  logic [63:0] qa[$];
  logic [63:0] qb[$];
  logic [63:0] ha, hb;
  bit          pa, pb;

  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete(); qb.delete();
      ha = '0; hb = '0; pa = 1'b0; pb = 1'b0;
    end else begin
      checks++;
      if (a_ack && b_ack) begin
        errors++; $display("FAIL both_ack a_ack=%0b b_ack=%0b required not both", a_ack, b_ack);
      end
      checks++;
      if ((a_ack && pa) || (b_ack && pb)) begin
        errors++; $display("FAIL ack_len ack held 2 cycles a=%0b b=%0b", a_ack, b_ack);
      end
      if (a_ack) begin
        checks++;
        if (qa.size() == 0) begin
          errors++; $display("FAIL a_unexpected_ack no access outstanding");
        end else begin
          ha = qa.pop_front();
          if (a_rdata !== ha) begin
            errors++; $display("FAIL a_rdata_sb got %h want %h", a_rdata, ha);
          end
        end
      end else begin
        checks++;
        if (a_rdata !== ha) begin
          errors++; $display("FAIL a_rdata_hold got %h want %h", a_rdata, ha);
        end
      end
      if (b_ack) begin
        checks++;
        if (qb.size() == 0) begin
          errors++; $display("FAIL b_unexpected_ack no access outstanding");
        end else begin
          hb = qb.pop_front();
          if (b_rdata !== hb) begin
            errors++; $display("FAIL b_rdata_sb got %h want %h", b_rdata, hb);
          end
        end
      end else begin
        checks++;
        if (b_rdata !== hb) begin
          errors++; $display("FAIL b_rdata_hold got %h want %h", b_rdata, hb);
        end
      end
      pa = a_ack; pb = b_ack;
    end
  end

  // Called just after a rising edge; drives a request and records its expectation.
  task automatic issue(input bit port, input bit we, input logic [5:0] addr, input logic [63:0] wd);
    if (we) ref_mem[addr] = wd;
    if (port == 1'b0) begin
      if (!we) exp_a = ref_mem[addr];
      qa.push_back(exp_a);
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end else begin
      if (!we) exp_b = ref_mem[addr];
      qb.push_back(exp_b);
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end
  endtask

  // n = number of falling edges waited up to and including the ack (0 on timeout).
  task automatic wait_ack(input bit port, input int budget, output int n,
                          output int we_cycles, output logic [5:0] we_addr);
    n = 0; we_cycles = 0; we_addr = '0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (d_mem_we) begin we_cycles++; we_addr = d_mem_addr; end
      if ((port == 1'b0 && a_ack) || (port == 1'b1 && b_ack)) begin
        n = i; break;
      end
    end
  endtask

  task automatic release_req(input bit port);
    @(posedge clk); #1;
    if (port == 1'b0) a_req = 1'b0; else b_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; a_req = 1'b0; b_req = 1'b0;
    exp_a = '0; exp_b = '0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic preload(input logic [5:0] addr, input logic [63:0] data);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_addr = addr; pre_data = data; ref_mem[addr] = data;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({a_ack, b_ack, busy, d_mem_we} !== 4'b0 || a_rdata !== '0 || b_rdata !== '0 ||
        d_mem_addr !== '0 || d_mem_data_in !== '0) begin
      errors++;
      $display("FAIL reset_outputs ack=%b%b busy=%b we=%b addr=%h ra=%h rb=%h want all 0",
               a_ack, b_ack, busy, d_mem_we, d_mem_addr, a_rdata, b_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_a_load_alone();
    int n, wc; logic [5:0] wa;
    preload(6'd1, 64'd5);
    preload(6'd2, 64'd17);
    issue(1'b0, 1'b0, 6'd2, 64'h0);
    wait_ack(1'b0, 10, n, wc, wa);
    checks++;
    if (n != 3) begin errors++; $display("FAIL a_load_latency got %0d want 3", n); end
    checks++;
    if (a_rdata !== 64'd17 || b_rdata !== 64'd0) begin
      errors++; $display("FAIL a_load_data a=%h b=%h want 17/0", a_rdata, b_rdata);
    end
    checks++;
    if (wc != 0) begin errors++; $display("FAIL a_load_we we_cycles %0d want 0", wc); end
    release_req(1'b0);
  endtask

  task automatic test_b_store_load();
    int n, wc; logic [5:0] wa;
    issue(1'b1, 1'b1, 6'd5, 64'h8000_0000_0000_0000);
    wait_ack(1'b1, 10, n, wc, wa);
    checks++;
    if (n != 3 || wc != 1 || wa !== 6'd5) begin
      errors++; $display("FAIL b_store_port n=%0d we_cycles=%0d addr=%0d want 3/1/5", n, wc, wa);
    end
    checks++;
    if (mem[5] !== 64'h8000_0000_0000_0000) begin
      errors++; $display("FAIL b_store_mem got %h want 8000000000000000", mem[5]);
    end
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 6'd5, 64'h0);
    wait_ack(1'b1, 10, n, wc, wa);
    checks++;
    if (n != 3 || wc != 0 || b_rdata !== 64'h8000_0000_0000_0000) begin
      errors++; $display("FAIL b_load_back n=%0d we_cycles=%0d b=%h want 3/0/8000000000000000", n, wc, b_rdata);
    end
    release_req(1'b1);
  endtask

  task automatic test_both_continuous();
    int  cyc[4];
    bit  who[4];
    int  k;
    do_reset();
    issue(1'b0, 1'b0, 6'd1, 64'h0);
    issue(1'b1, 1'b0, 6'd2, 64'h0);
    qa.push_back(64'd5);
    qb.push_back(64'd17);
    k = 0;
    for (int i = 1; i <= 30 && k < 4; i++) begin
      @(negedge clk);
      if (a_ack) begin who[k] = 1'b0; cyc[k] = i; k++; end
      else if (b_ack) begin who[k] = 1'b1; cyc[k] = i; k++; end
    end
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b0;
    checks++;
    if (k != 4) begin
      errors++; $display("FAIL rr_count got %0d acks want 4", k);
    end else begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (who[j] !== j[0] || cyc[j] != 3 + 3 * j) begin
          errors++; $display("FAIL rr_order ack%0d port=%0d cycle=%0d want port %0d cycle %0d",
                             j, who[j], cyc[j], j[0], 3 + 3 * j);
        end
      end
    end
    checks++;
    if (a_rdata !== 64'd5 || b_rdata !== 64'd17) begin
      errors++; $display("FAIL rr_data a=%h b=%h want 5/17", a_rdata, b_rdata);
    end
  endtask

  task automatic test_lone_after_other();
    bit         port_t [3] = '{1'b1, 1'b0, 1'b0};
    logic [5:0] addr_t [3] = '{6'd1, 6'd2, 6'd1};
    int n, wc; logic [5:0] wa;
    for (int i = 0; i < 3; i++) begin
      issue(port_t[i], 1'b0, addr_t[i], 64'h0);
      wait_ack(port_t[i], 10, n, wc, wa);
      checks++;
      if (n != 3) begin errors++; $display("FAIL lone_grant step%0d latency %0d want 3", i, n); end
      release_req(port_t[i]);
    end
  endtask

  task automatic test_reset_mid_access();
    int n, wc; logic [5:0] wa;
    issue(1'b1, 1'b1, 6'd9, 64'hDEAD_BEEF_0000_1234);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (d_mem_we !== 1'b1 || d_mem_addr !== 6'd9) begin
      errors++; $display("FAIL rst_pre_access we=%b addr=%0d want 1/9", d_mem_we, d_mem_addr);
    end
    #1;
    rst_n = 1'b0; b_req = 1'b0; exp_a = '0; exp_b = '0;
    #1;
    checks++;
    if ({a_ack, b_ack, busy, d_mem_we} !== 4'b0 || a_rdata !== '0 || b_rdata !== '0 ||
        d_mem_addr !== '0 || d_mem_data_in !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs ack=%b%b busy=%b we=%b addr=%h ra=%h rb=%h want all 0",
               a_ack, b_ack, busy, d_mem_we, d_mem_addr, a_rdata, b_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (a_ack || b_ack || busy) begin
        errors++; $display("FAIL rst_mid_quiet ack=%b%b busy=%b want 0", a_ack, b_ack, busy);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(1'b0, 1'b0, 6'd1, 64'h0);
    wait_ack(1'b0, 10, n, wc, wa);
    checks++;
    if (n != 3 || a_rdata !== 64'd5) begin
      errors++; $display("FAIL rst_recover n=%0d a=%h want 3/5", n, a_rdata);
    end
    release_req(1'b0);
  endtask

  task automatic test_drop_during_access();
    issue(1'b0, 1'b0, 6'd2, 64'h0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || d_mem_addr !== 6'd2) begin
      errors++; $display("FAIL drop_access busy=%b addr=%0d want 1/2", busy, d_mem_addr);
    end
    #1;
    a_req = 1'b0;
    @(negedge clk);
    checks++;
    if (a_ack !== 1'b1 || a_rdata !== 64'd17) begin
      errors++; $display("FAIL drop_ack a_ack=%b a=%h want 1/17", a_ack, a_rdata);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || a_ack !== 1'b0) begin
      errors++; $display("FAIL drop_idle busy=%b a_ack=%b want 0/0", busy, a_ack);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    exp_a = '0; exp_b = '0;
    rst_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    test_reset();
    test_a_load_alone();
    test_b_store_load();
    test_both_continuous();
    test_lone_after_other();
    test_reset_mid_access();
    test_drop_during_access();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
